// File: rtl/xpmwrap_pkg.sv
// Shared types for the TDP RAM stream reader.
//   rd_state_t  : burst controller states (IDLE, READ, DRAIN)
//   trk_entry_t : one stage of the RAM read-latency tracker {valid, last}
//   cnt_width() : width of a counter that must hold 0..depth inclusive
package xpmwrap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } trk_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xpmwrap_skid_fifo.sv
// Synchronous FIFO absorbing RAM read latency ahead of the output stream.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset (clears contents too)
//   wr_en_i       : push wr_data_i (honoured when not full, or full with a pop)
//   rd_en_i       : pop head entry (ignored when empty)
//   rd_data_o     : head entry, straight from the storage registers
//   count_o       : occupancy 0..DEPTH
//   empty_o/full_o: occupancy flags
// DEPTH must be a power of two; pointers wrap by natural overflow.
module xpmwrap_skid_fifo
  import xpmwrap_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  input  logic                          rd_en_i,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH[CW-1:0]);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so push+pop on a full FIFO both land.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xpmwrap_tdpram_stream_reader.sv
// Read-side burst master for one port of a fixed-latency true dual port RAM.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : burst command handshake (ready only in IDLE)
//   cmd_addr, cmd_len    : first word address, word count minus one
//   ram_en, ram_addr     : one RAM read per cycle with ram_en high
//   ram_regce            : RAM output register enable, 1 once out of reset
//   ram_dout             : RAM read data, READ_LATENCY cycles after ram_en
//   m_valid/m_ready      : output stream handshake
//   m_data, m_last       : stream word and end-of-burst marker
//   busy                 : high from command accept until last word popped
module xpmwrap_tdpram_stream_reader
  import xpmwrap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned SKID_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  ram_en,
  output logic                  ram_regce,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned CW = cnt_width(SKID_DEPTH);
  localparam logic [CW:0] DEPTH_L = SKID_DEPTH[CW:0];

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  run_q;
  trk_entry_t            trk_q [READ_LATENCY];

  logic [CW:0]           inflight;
  logic [CW:0]           credit_used;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DATA_WIDTH:0]   fifo_rd;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_rd[DATA_WIDTH-1:0];
  assign m_last    = m_valid && fifo_rd[DATA_WIDTH];
  assign pop       = m_valid && m_ready;

  assign cmd_ready = (state_q == IDLE) && run_q;
  assign busy      = (state_q != IDLE);
  assign ram_regce = run_q;
  assign ram_addr  = ptr_q;
  assign ram_en    = issue;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {{CW{1'b0}}, trk_q[i].valid};
    end
  end

  // The slot freed by this cycle's pop is counted as available, which keeps
  // the pipeline full at one word per cycle when SKID_DEPTH >= READ_LATENCY+1.
  assign credit_used = inflight + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign issue       = (state_q == READ) && (credit_used < DEPTH_L);
  assign issue_last  = (rem_q == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ptr_d   = cmd_addr;
          rem_d   = cmd_len;
          state_d = READ;
        end
      end
      READ: begin
        if (issue) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          if (issue_last) begin
            state_d = DRAIN;
          end else begin
            rem_d = rem_q - (ADDR_WIDTH + 1)'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && m_last && (inflight == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      run_q   <= 1'b0;
      trk_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      run_q    <= 1'b1;
      trk_q[0] <= trk_entry_t'{valid: issue, last: issue && issue_last};
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        trk_q[i] <= trk_q[i-1];
      end
    end
  end

  assign fifo_wr = trk_q[READ_LATENCY-1].valid;

  xpmwrap_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({trk_q[READ_LATENCY-1].last, ram_dout}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_wr && fifo_full && !pop));

endmodule

// File: tb/tb_xpmwrap_tdpram_stream_reader.sv
module tb_xpmwrap_tdpram_stream_reader;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 2;
  localparam int unsigned SD = 4;

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          ram_en;
  logic          ram_regce;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  xpmwrap_tdpram_stream_reader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .SKID_DEPTH   (SD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_en    (ram_en),
    .ram_regce (ram_regce),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address sampled with ram_en, data emerges RL edges later.
  logic [DW-1:0] mem  [64];
  logic [DW-1:0] pipe [RL];

  always @(posedge clk) begin
    if (ram_en) pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) begin
      if (ram_regce) pipe[i] <= pipe[i-1];
    end
  end
  assign ram_dout = pipe[RL-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expected issue addresses and stream beats, built from the
  // bench memory when a command handshake is seen.
  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_beat_q [$];
  int            outstanding = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_addr_q.delete();
      exp_beat_q.delete();
      outstanding = 0;
    end else begin
      int nxt;
      nxt = outstanding + (ram_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (ram_en) begin
        if (exp_addr_q.size() == 0) begin
          check("spurious_issue", 64'(ram_en), 64'd0);
        end else begin
          check("ram_addr", 64'(ram_addr), 64'(exp_addr_q[0]));
          void'(exp_addr_q.pop_front());
        end
        check("credit_limit", 64'(nxt <= int'(SD)), 64'd1);
      end
      if (m_valid) begin
        if (exp_beat_q.size() == 0) begin
          check("stale_beat", 64'(m_valid), 64'd0);
        end else begin
          check("m_data", 64'(m_data), 64'(exp_beat_q[0][DW-1:0]));
          check("m_last", 64'(m_last), 64'(exp_beat_q[0][DW]));
          if (m_ready) void'(exp_beat_q.pop_front());
        end
      end
      outstanding = nxt;
      if (cmd_valid && cmd_ready) begin
        for (int unsigned k = 0; k <= 32'(cmd_len); k++) begin
          logic [AW-1:0] a;
          a = cmd_addr + AW'(k);
          exp_addr_q.push_back(a);
          exp_beat_q.push_back({k == 32'(cmd_len), mem[a]});
        end
      end
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    int unsigned   rdy_on;
    int unsigned   rdy_off;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_final;
    int unsigned   exp_beats;
    int unsigned   exp_lat;
    int unsigned   exp_span;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned first_c, first_pop, last_pop, beats;
    logic done;
    mem[v.poke_addr] = v.poke_data;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    m_ready   = 1'b0;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    first_c = 0; first_pop = 0; last_pop = 0; beats = 0; done = 1'b0;
    for (int unsigned c = 1; c <= 600 && !done; c++) begin
      m_ready = (((c - 1) % (v.rdy_on + v.rdy_off)) < v.rdy_on);
      @(negedge clk);
      if (c == 1) check("busy_after_accept", 64'(busy), 64'd1);
      if (m_valid && first_c == 0) first_c = c;
      if (m_valid && m_ready) begin
        if (beats == 0) begin
          first_pop = c;
          check("first_data", 64'(m_data), 64'(v.exp_first));
        end
        beats++;
        if (m_last) begin
          done = 1'b1;
          last_pop = c;
          check("final_data", 64'(m_data), 64'(v.exp_final));
        end
      end
      tick();
    end
    check("burst_done", 64'(done), 64'd1);
    check("beats", 64'(beats), 64'(v.exp_beats));
    check("latency", 64'(first_c), 64'(v.exp_lat));
    check("span", 64'(last_pop - first_pop), 64'(v.exp_span));
    m_ready = 1'b0;
    @(negedge clk);
    check("busy_low_after_last", 64'(busy), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("beats_all_seen", 64'(exp_beat_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pops;
    int unsigned stale;
    logic acc, got_b;

    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    for (int i = 0; i < RL; i++) pipe[i] = '0;

    vecs[0] = '{addr: 6'd5,  len: 7'd0,   poke_addr: 6'd5,  poke_data: 32'hDEADBEEF,
                rdy_on: 1, rdy_off: 0, exp_first: 32'hDEADBEEF, exp_final: 32'hDEADBEEF,
                exp_beats: 1, exp_lat: 4, exp_span: 0};
    vecs[1] = '{addr: 6'd0,  len: 7'd15,  poke_addr: 6'd5,  poke_data: 32'd5,
                rdy_on: 1, rdy_off: 0, exp_first: 32'd0, exp_final: 32'd15,
                exp_beats: 16, exp_lat: 4, exp_span: 15};
    vecs[2] = '{addr: 6'd62, len: 7'd3,   poke_addr: 6'd62, poke_data: 32'h620000AA,
                rdy_on: 1, rdy_off: 0, exp_first: 32'h620000AA, exp_final: 32'd1,
                exp_beats: 4, exp_lat: 4, exp_span: 3};
    vecs[3] = '{addr: 6'd8,  len: 7'd7,   poke_addr: 6'd8,  poke_data: 32'd8,
                rdy_on: 1, rdy_off: 3, exp_first: 32'd8, exp_final: 32'd15,
                exp_beats: 8, exp_lat: 4, exp_span: 28};
    vecs[4] = '{addr: 6'd33, len: 7'd127, poke_addr: 6'd33, poke_data: 32'd33,
                rdy_on: 1, rdy_off: 0, exp_first: 32'd33, exp_final: 32'd32,
                exp_beats: 128, exp_lat: 4, exp_span: 127};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_ram_en",    64'(ram_en),    64'd0);
    check("rst_ram_addr",  64'(ram_addr),  64'd0);
    check("rst_ram_regce", 64'(ram_regce), 64'd0);
    check("rst_m_valid",   64'(m_valid),   64'd0);
    check("rst_m_last",    64'(m_last),    64'd0);
    check("rst_m_data",    64'(m_data),    64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_regce",     64'(ram_regce), 64'd1);
    check("post_rst_busy",      64'(busy),      64'd0);
    tick();

    for (int unsigned i = 0; i < 5; i++) run_vec(vecs[i]);

    // Second command held during a burst must wait for IDLE.
    cmd_addr = 6'd10; cmd_len = 7'd7; cmd_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    check("cmd_a_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_addr = 6'd40; cmd_len = 7'd0;
    pops = 0; acc = 1'b0;
    for (int unsigned c = 1; c <= 100 && !acc; c++) begin
      @(negedge clk);
      if (c == 2) check("cmd_ready_while_busy", 64'(cmd_ready), 64'd0);
      if (cmd_ready) begin
        acc = 1'b1;
        check("cmd_b_after_a_drained", 64'(pops), 64'd8);
      end
      if (m_valid && m_ready) pops++;
      tick();
    end
    check("cmd_b_accepted", 64'(acc), 64'd1);
    cmd_valid = 1'b0;
    got_b = 1'b0;
    for (int unsigned c = 1; c <= 50 && !got_b; c++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) begin
        got_b = 1'b1;
        check("cmd_b_data", 64'(m_data), 64'd40);
      end
      tick();
    end
    check("cmd_b_done", 64'(got_b), 64'd1);
    tick();

    // Reset after three beats of a ten-word burst.
    cmd_addr = 6'd20; cmd_len = 7'd9; cmd_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    check("rst_burst_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    pops = 0;
    for (int unsigned c = 1; c <= 60 && pops < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) pops++;
      tick();
    end
    check("pre_reset_beats", 64'(pops), 64'd3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_m_valid",   64'(m_valid),   64'd0);
    check("midrst_busy",      64'(busy),      64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    @(negedge clk);
    check("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("after_rst_busy",      64'(busy),      64'd0);
    check("after_rst_m_valid",   64'(m_valid),   64'd0);
    stale = 0;
    for (int unsigned c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (m_valid || ram_en) stale++;
    end
    check("no_stale_after_reset", 64'(stale), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
